i2s_audio_tx: RTL and testbench

//   Serialises the guest core's stereo PCM samples onto the board's I2S pins (I2S_BCK/I2S_LRCK/I2S_DATA).

---
 rtl/i2s_audio_tx.sv | 78 +++++++
 tb/tb_i2s_audio_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: divides clk into BCK/LRCK and shifts one latched stereo pair out per 64-BCK frame.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing; default is Philips I2S (MSB one BCK after LRCK).
module i2s_audio_tx #(
  parameter int CLK_DIV  = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  output logic                sample_ack,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                bck_q, lrck_q, data_q, ack_q;

  logic                div_wrap, fall, latch, ser_bit;
  logic [5:0]          slot_pos;
  logic [4:0]          slot_bit;
  logic [SAMPLE_W-1:0] chan, shifted;

  // Slot position of the bit shown for the new bit_cnt value.
`ifdef I2S_LEFT_JUSTIFIED_EN
  assign slot_pos = bit_cnt_d;
`else
  assign slot_pos = bit_cnt_d - 6'd1;
`endif

  always_comb begin
    div_wrap  = (div_cnt_q == DW'(CLK_DIV - 1));
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
    fall      = div_wrap & bck_q;
    bit_cnt_d = fall ? bit_cnt_q + 6'd1 : bit_cnt_q;
    latch     = fall && (bit_cnt_d == 6'd0);
    hold_l_d  = latch ? left_in  : hold_l_q;
    hold_r_d  = latch ? right_in : hold_r_q;
    slot_bit  = slot_pos[4:0];
    chan      = slot_pos[5] ? hold_r_d : hold_l_d;
    // Zero-fill shift: slot bits at or beyond SAMPLE_W come out as pad zeros.
    shifted   = chan << slot_bit;
    ser_bit   = shifted[SAMPLE_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      bit_cnt_q <= 6'd63;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      bck_q     <= 1'b0;
      lrck_q    <= 1'b0;
      data_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      bck_q     <= div_wrap ? ~bck_q : bck_q;
      lrck_q    <= fall ? bit_cnt_d[5] : lrck_q;
      data_q    <= fall ? ser_bit : data_q;
      ack_q     <= latch;
    end
  end

  assign sample_ack = ack_q;
  assign i2s_bck    = bck_q;
  assign i2s_lrck   = lrck_q;
  assign i2s_data   = data_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx (CLK_DIV=8, SAMPLE_W=16); frames captured on BCK falling edges.
module tb_i2s_audio_tx;
  localparam int CLK_DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] left_in = 16'h8001;
  logic [15:0] right_in = 16'h7FFE;
  logic        sample_ack, i2s_bck, i2s_lrck, i2s_data;

  int errs = 0;
  int checks = 0;

  i2s_audio_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_W(16)) dut (
    .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in),
    .sample_ack(sample_ack), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Index 63-i holds the bit shown after the fall where bit_cnt becomes i.
  function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
`ifdef I2S_LEFT_JUSTIFIED_EN
    return {l, 16'h0, r, 16'h0};
`else
    return {1'b0, l, 16'h0, r, 15'h0};
`endif
  endfunction

  localparam logic [63:0] LRCK_FRAME = {32'h0, 32'hFFFF_FFFF};

  // Called #1 after a posedge; returns outputs right after the next BCK 1->0 transition.
  task automatic next_fall(output logic lr, output logic d, output logic a, output bit ok);
    logic prev;
    int   n;
    prev = i2s_bck; ok = 1'b0; n = 0;
    lr = 1'b0; d = 1'b0; a = 1'b0;
    while (!ok && n < 64) begin
      @(posedge clk); #1;
      if (prev && !i2s_bck) begin
        lr = i2s_lrck; d = i2s_data; a = sample_ack; ok = 1'b1;
      end
      prev = i2s_bck;
      n++;
    end
  endtask

  task automatic capture_frame(input int chg_at, input logic [15:0] chg_val,
                               output logic [63:0] dv, output logic [63:0] lv);
    logic lr, d, a;
    bit   ok;
    int   n;
    dv = '0; lv = '0; a = 1'b0; ok = 1'b1; n = 0; lr = 1'b0; d = 1'b0;
    while (!a && ok && n < 70) begin
      next_fall(lr, d, a, ok);
      n++;
    end
    chk("frame_sync", {63'h0, a}, 64'h1);
    for (int i = 0; i < 64; i++) begin
      if (i > 0) next_fall(lr, d, a, ok);
      if (!ok) begin
        chk("fall_timeout", 64'h0, 64'h1);
        break;
      end
      dv[63-i] = d;
      lv[63-i] = lr;
      if (i == chg_at) left_in = chg_val;
    end
  endtask

  initial begin
    logic [63:0] dv, lv;
    logic        lr, d, a;
    bit          ok;
    int          first_rise, first_fall, ack_at, ack_cnt, first_data, last, n;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("reset_outs", {60'h0, i2s_bck, i2s_lrck, i2s_data, sample_ack}, 64'h0);

    // First BCK edges and first latch after release
    @(negedge clk) reset = 1'b0;
    first_rise = 0; first_fall = 0; ack_at = 0; ack_cnt = 0; first_data = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (i2s_bck && first_rise == 0) first_rise = c;
      if (!i2s_bck && first_rise != 0 && first_fall == 0) begin
        first_fall = c;
        first_data = int'(i2s_data);
      end
      if (sample_ack) begin
        if (ack_at == 0) ack_at = c;
        ack_cnt++;
      end
    end
    chk("bck_first_rise", 64'(first_rise), 64'd8);
    chk("bck_first_fall", 64'(first_fall), 64'd16);
    chk("first_ack_clk", 64'(ack_at), 64'd16);
    chk("first_ack_width", 64'(ack_cnt), 64'd1);
`ifdef I2S_LEFT_JUSTIFIED_EN
    chk("data_at_lrck_edge", 64'(first_data), 64'd1);
`else
    chk("data_at_lrck_edge", 64'(first_data), 64'd0);
`endif

    // Full frame content and LRCK shape
    capture_frame(-1, 16'h0, dv, lv);
    chk("frame_8001_7ffe", dv, exp_frame(16'h8001, 16'h7FFE));
    chk("frame_lrck", lv, LRCK_FRAME);

    // Ten frames: one 1-clk ack every 1024 clk
    n = 0;
    while (!sample_ack && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_sync", {63'h0, sample_ack}, 64'h1);
    last = 0; ack_cnt = 0;
    for (int c = 1; c <= 10 * 128 * CLK_DIV; c++) begin
      @(posedge clk); #1;
      if (sample_ack) begin
        chk("ack_spacing", 64'(c - last), 64'(128 * CLK_DIV));
        last = c;
        ack_cnt++;
      end
    end
    chk("ack_count_10", 64'(ack_cnt), 64'd10);

    // Mid-frame input change only shows in the following frame
    capture_frame(10, 16'hFFFF, dv, lv);
    chk("frame_unchanged", dv, exp_frame(16'h8001, 16'h7FFE));
    capture_frame(-1, 16'h0, dv, lv);
    chk("frame_ffff", dv, exp_frame(16'hFFFF, 16'h7FFE));
    chk("frame_ffff_lrck", lv, LRCK_FRAME);

    // Reset in the middle of a frame (bit_cnt=20)
    a = 1'b0; ok = 1'b1; n = 0;
    while (!a && ok && n < 70) begin
      next_fall(lr, d, a, ok);
      n++;
    end
    for (int i = 0; i < 20; i++) next_fall(lr, d, a, ok);
    chk("mid_lrck_left", {63'h0, i2s_lrck}, 64'h0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("midreset_outs", {60'h0, i2s_bck, i2s_lrck, i2s_data, sample_ack}, 64'h0);
    end
    reset = 1'b0;
    ack_at = 0;
    for (int c = 1; c <= 100 && ack_at == 0; c++) begin
      @(posedge clk); #1;
      if (sample_ack) ack_at = c;
    end
    chk("ack_after_reset", 64'(ack_at), 64'd16);
    capture_frame(-1, 16'h0, dv, lv);
    chk("frame_after_reset", dv, exp_frame(16'hFFFF, 16'h7FFE));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
